// File: rtl/hazard_control_unit.sv
// Hazard detection and stall control beside the ID stage: load-use semi stalls,
// NPU/cache full stalls, a registered stall class, stall statistics and a full-stall watchdog.
module hazard_control_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_NPU_CH = 3,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic [REG_ADDR_W-1:0] iIdRegRs,
    input  logic [REG_ADDR_W-1:0] iIdRegRt,
    input  logic [REG_ADDR_W-1:0] iExRegRt,
    input  logic                  iExMemRead,
    input  logic                  iExRetCmd,
    input  logic [NUM_NPU_CH-1:0] iNpuOp,
    input  logic [NUM_NPU_CH-1:0] iNpuBlocked,
    input  logic                  iInstrCacheValid,
    input  logic                  iInstrCacheReady,
    input  logic                  iDataCacheValid,
    input  logic                  iDataCacheReady,
    input  logic                  iClearStats,
    output logic                  oSemiStall,
    output logic                  oFullStall,
    output logic [1:0]            oStallState,
    output logic [CNT_W-1:0]      oSemiCount,
    output logic [CNT_W-1:0]      oNpuCount,
    output logic [CNT_W-1:0]      oCacheCount,
    output logic                  oStallTimeout
);

    localparam int unsigned SB_DEPTH = LOAD_LAT - 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_SEMI = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic       exLoad;
    logic       exHit;
    logic       sbHit;
    logic       dataHazard;
    logic       npuHazard;
    logic       cacheHazard;
    logic [1:0] stateQ;
    logic [1:0] stateNext;
    logic [CNT_W-1:0] wdCnt;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic regMatch(input logic [REG_ADDR_W-1:0] src,
                                      input logic [REG_ADDR_W-1:0] dst);
        return (dst != '0) && (src == dst);
    endfunction

    assign exLoad = iExMemRead & ~iExRetCmd;
    assign exHit  = exLoad & (regMatch(iIdRegRs, iExRegRt) | regMatch(iIdRegRt, iExRegRt));

    // Loads that have left EX but whose data is still in flight.
    if (SB_DEPTH > 0) begin : genSb
        logic [SB_DEPTH-1:0]   sbValid;
        logic [REG_ADDR_W-1:0] sbRt [SB_DEPTH];

        always_ff @(posedge iClk) begin
            if (iReset) begin
                sbValid <= '0;
                for (int i = 0; i < int'(SB_DEPTH); i++) begin
                    sbRt[i] <= '0;
                end
            end else if (!oFullStall) begin
                sbValid[0] <= exLoad;
                sbRt[0]    <= iExRegRt;
                for (int i = 1; i < int'(SB_DEPTH); i++) begin
                    sbValid[i] <= sbValid[i-1];
                    sbRt[i]    <= sbRt[i-1];
                end
            end
        end

        always_comb begin
            sbHit = 1'b0;
            for (int i = 0; i < int'(SB_DEPTH); i++) begin
                if (sbValid[i] && (regMatch(iIdRegRs, sbRt[i]) || regMatch(iIdRegRt, sbRt[i]))) begin
                    sbHit = 1'b1;
                end
            end
        end
    end else begin : genNoSb
        assign sbHit = 1'b0;
    end

    assign dataHazard  = exHit | sbHit;
    assign npuHazard   = |(iNpuOp & iNpuBlocked);
    assign cacheHazard = (iInstrCacheValid & ~iInstrCacheReady) |
                         (iDataCacheValid & ~iDataCacheReady);
    assign oFullStall  = npuHazard | cacheHazard;
    assign oSemiStall  = dataHazard & ~oFullStall;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateQ <= ST_RUN;
        end else begin
            stateQ <= stateNext;
        end
    end

    always_comb begin
        stateNext = ST_RUN;
        if (oFullStall) begin
            stateNext = ST_FULL;
        end else if (oSemiStall) begin
            stateNext = ST_SEMI;
        end
    end

    assign oStallState = stateQ;

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge iClk) begin
        if (iReset || iClearStats) begin
            oSemiCount  <= '0;
            oNpuCount   <= '0;
            oCacheCount <= '0;
        end else begin
            if (oSemiStall && (oSemiCount != CNT_MAX)) begin
                oSemiCount <= oSemiCount + CNT_W'(1);
            end
            if (npuHazard && (oNpuCount != CNT_MAX)) begin
                oNpuCount <= oNpuCount + CNT_W'(1);
            end
            if (cacheHazard && (oCacheCount != CNT_MAX)) begin
                oCacheCount <= oCacheCount + CNT_W'(1);
            end
        end
    end

    // Watchdog counts consecutive full stalls; the flag is sticky.
    always_ff @(posedge iClk) begin
        if (iReset || iClearStats) begin
            wdCnt         <= '0;
            oStallTimeout <= 1'b0;
        end else if (!oFullStall) begin
            wdCnt <= '0;
        end else begin
            if (wdCnt != WD_LIMIT) begin
                wdCnt <= wdCnt + CNT_W'(1);
            end
            if (wdCnt >= WD_LAST) begin
                oStallTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one instance with LOAD_LAT=1 and one with LOAD_LAT=3,
// both with CNT_W=4 and TIMEOUT=8, sharing the same stimulus.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, exRt;
    logic       exMemRead, exRet;
    logic [2:0] npuOp, npuBlk;
    logic       icV, icR, dcV, dcR, clr;

    logic       semi1, full1, to1;
    logic [1:0] state1;
    logic [3:0] semiCnt1, npuCnt1, cacheCnt1;
    logic       semi3, full3, to3;
    logic [1:0] state3;
    logic [3:0] semiCnt3, npuCnt3, cacheCnt3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_ADDR_W(5), .NUM_NPU_CH(3), .LOAD_LAT(1), .CNT_W(4), .TIMEOUT(8)) dut1 (
        .iClk(clk), .iReset(rst), .iIdRegRs(rs), .iIdRegRt(rt), .iExRegRt(exRt),
        .iExMemRead(exMemRead), .iExRetCmd(exRet), .iNpuOp(npuOp), .iNpuBlocked(npuBlk),
        .iInstrCacheValid(icV), .iInstrCacheReady(icR), .iDataCacheValid(dcV), .iDataCacheReady(dcR),
        .iClearStats(clr), .oSemiStall(semi1), .oFullStall(full1), .oStallState(state1),
        .oSemiCount(semiCnt1), .oNpuCount(npuCnt1), .oCacheCount(cacheCnt1), .oStallTimeout(to1)
    );

    hazard_control_unit #(.REG_ADDR_W(5), .NUM_NPU_CH(3), .LOAD_LAT(3), .CNT_W(4), .TIMEOUT(8)) dut3 (
        .iClk(clk), .iReset(rst), .iIdRegRs(rs), .iIdRegRt(rt), .iExRegRt(exRt),
        .iExMemRead(exMemRead), .iExRetCmd(exRet), .iNpuOp(npuOp), .iNpuBlocked(npuBlk),
        .iInstrCacheValid(icV), .iInstrCacheReady(icR), .iDataCacheValid(dcV), .iDataCacheReady(dcR),
        .iClearStats(clr), .oSemiStall(semi3), .oFullStall(full3), .oStallState(state3),
        .oSemiCount(semiCnt3), .oNpuCount(npuCnt3), .oCacheCount(cacheCnt3), .oStallTimeout(to3)
    );

    task automatic checkVal(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs = '0; rt = '0; exRt = '0; exMemRead = 1'b0; exRet = 1'b0;
        npuOp = '0; npuBlk = '0; icV = 1'b0; icR = 1'b0; dcV = 1'b0; dcR = 1'b0; clr = 1'b0;
    endtask

    task automatic cacheStalls(input int n);
        for (int i = 0; i < n; i++) begin
            icV = 1'b1;
            tick();
        end
        icV = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        checkVal("rst_state", int'(state3), 0);
        checkVal("rst_semiCnt", int'(semiCnt3), 0);
        checkVal("rst_cacheCnt", int'(cacheCnt3), 0);
        checkVal("rst_timeout", int'(to3), 0);
        checkVal("rst_semi_comb", int'(semi3), 0);
        rst = 1'b0;

        // LOAD_LAT=1 basic load-use
        exMemRead = 1'b1; exRt = 5'd5; rs = 5'd5; #3;
        checkVal("ll1_use", int'(semi1), 1);
        checkVal("ll3_use", int'(semi3), 1);
        tick();
        exRet = 1'b1; #3;
        checkVal("ll1_ret", int'(semi1), 0);
        tick();
        exRet = 1'b0; exRt = '0; rs = '0; #3;
        checkVal("ll1_r0", int'(semi1), 0);
        tick();
        idle(); tick(); tick(); tick();

        // LOAD_LAT=3 window, no full stall
        exMemRead = 1'b1; exRt = 5'd7; rt = 5'd7; #3;
        checkVal("win_c0", int'(semi3), 1);
        tick();
        exMemRead = 1'b0; exRt = '0; #3;
        checkVal("win_c1", int'(semi3), 1);
        checkVal("win_c1_ll1", int'(semi1), 0);
        checkVal("win_state_semi", int'(state3), 1);
        tick(); #3;
        checkVal("win_c2", int'(semi3), 1);
        tick(); #3;
        checkVal("win_c3", int'(semi3), 0);
        tick();
        idle(); tick(); tick(); tick();

        // LOAD_LAT=3 window extended by a full stall
        exMemRead = 1'b1; exRt = 5'd7; rt = 5'd7; #3;
        checkVal("ext_c0", int'(semi3), 1);
        tick();
        exMemRead = 1'b0; exRt = '0; icV = 1'b1; #3;
        checkVal("ext_c1_full", int'(full3), 1);
        checkVal("ext_c1_semi", int'(semi3), 0);
        tick();
        icV = 1'b0; #3;
        checkVal("ext_state_full", int'(state3), 2);
        checkVal("ext_c2", int'(semi3), 1);
        tick(); #3;
        checkVal("ext_c3", int'(semi3), 1);
        tick(); #3;
        checkVal("ext_c4", int'(semi3), 0);
        tick();
        idle(); tick(); tick(); tick();

        // NPU channel hazards
        npuOp = 3'b010; npuBlk = 3'b010; #3;
        checkVal("npu_hit", int'(full3), 1);
        tick();
        npuBlk = 3'b101; #3;
        checkVal("npu_miss", int'(full3), 0);
        tick();
        npuBlk = 3'b010; exMemRead = 1'b1; exRt = 5'd5; rs = 5'd5; #3;
        checkVal("npu_prio_full", int'(full1), 1);
        checkVal("npu_prio_semi1", int'(semi1), 0);
        checkVal("npu_prio_semi3", int'(semi3), 0);
        tick();
        checkVal("npu_state", int'(state3), 2);
        checkVal("npu_cnt", int'(npuCnt3), 2);
        idle(); tick(); tick(); tick();

        // Cache stall counting with overlapping I/D misses
        clr = 1'b1; tick(); clr = 1'b0;
        checkVal("clr_npu", int'(npuCnt3), 0);
        checkVal("clr_cache", int'(cacheCnt3), 0);
        for (int i = 0; i < 4; i++) begin
            icV = 1'b1;
            dcV = (i == 1 || i == 2);
            tick();
            checkVal("cache_state", int'(state3), 2);
        end
        idle(); tick();
        checkVal("cache_state_run", int'(state3), 0);
        checkVal("cache_cnt", int'(cacheCnt3), 4);

        // Watchdog
        cacheStalls(7);
        checkVal("wd_7a", int'(to3), 0);
        tick();
        cacheStalls(7);
        checkVal("wd_7b", int'(to3), 0);
        tick();
        cacheStalls(7);
        checkVal("wd_7c", int'(to3), 0);
        cacheStalls(1);
        checkVal("wd_8", int'(to3), 1);
        tick();
        checkVal("wd_sticky", int'(to3), 1);
        checkVal("cache_sat", int'(cacheCnt3), 15);
        clr = 1'b1; tick(); clr = 1'b0;
        checkVal("wd_clr", int'(to3), 0);
        checkVal("wd_clr_cnt", int'(cacheCnt3), 0);

        // Semi counter saturation, clear during stall, reset mid-stall
        exMemRead = 1'b1; exRt = 5'd5; rs = 5'd5;
        for (int i = 0; i < 20; i++) tick();
        checkVal("semi_sat", int'(semiCnt1), 15);
        checkVal("semi_state", int'(state1), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        checkVal("semi_clr", int'(semiCnt1), 0);
        tick();
        checkVal("semi_after_clr", int'(semiCnt1), 1);
        rst = 1'b1; tick(); #3;
        checkVal("rst_mid_cnt", int'(semiCnt1), 0);
        checkVal("rst_mid_state", int'(state1), 0);
        checkVal("rst_mid_semi", int'(semi1), 1);
        rst = 1'b0;
        idle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
